// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and helpers for the ALU operation sequencer:
//   - state_t  : sequencer FSM states (3-bit encoding, also exported on state_dbg)
//   - OP_*     : 3-bit opcode encodings understood by the ALU
//   - CNT_W    : width of the latency down-counter (ALU_LAT is 1..15)
//   - is_unary : opcode takes only operand A
//   - is_legal : opcode byte is a usable opcode
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      EXEC   = 3'd3,
      WAIT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_NOT  = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   localparam int CNT_W = 4;

   function automatic logic is_unary(input logic [2:0] op);
      return (op == OP_NOT) || (op == OP_SHL);
   endfunction

   // b is the zero-extended input byte; any bit at or above op_w makes it
   // illegal, as does the reserved code.
   function automatic logic is_legal(input logic [31:0] b, input int op_w);
      logic [31:0] hi;
      hi = b >> op_w;
      return (hi == 32'd0) && (b[2:0] != OP_RSVD);
   endfunction

endpackage

// File: rtl/alu_seq_lat_timer.sv
// -----------------------------------------------------------------------------
// alu_seq_lat_timer
// Loadable down-counter that measures the ALU latency while the sequencer
// sits in WAIT. It stops at zero; o_done is high whenever the count is zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   i_ena       : enable; low freezes the count
//   i_load      : load i_load_val (takes priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one (saturates at zero)
//   o_done      : count is zero
// -----------------------------------------------------------------------------
module alu_seq_lat_timer
   import alu_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ena,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_ena) begin
         if (i_load) begin
            r_count <= i_load_val;
         end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Collects opcode, operand A and (for binary ops) operand B from a valid/ready
// byte stream, launches one ALU operation, waits ALU_LAT cycles, captures the
// result and flags, and holds them on a valid/ready output until consumed.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   ena                    : global enable; low freezes every register
//   in_valid/in_ready/in_data : input byte stream (opcode, A, B)
//   alu_start              : one-cycle pulse, ALU inputs valid
//   alu_op/alu_a/alu_b     : registered ALU inputs (alu_b = 0 for unary ops)
//   alu_result/alu_carry   : ALU outputs, sampled ALU_LAT cycles after start
//   out_valid/out_ready/out_data/out_flags : result stream, flags={carry,zero}
//   err                    : one-cycle pulse after an illegal opcode byte
//   busy                   : FSM not in IDLE
//   state_dbg              : raw FSM state
// -----------------------------------------------------------------------------
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int OP_W    = 3,
   parameter int ALU_LAT = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             alu_start,
   output logic [OP_W-1:0]  alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_flags,
   output logic             err,
   output logic             busy,
   output logic [2:0]       state_dbg
);

   // WAIT spends ALU_LAT cycles: the load value plus the cycle at zero.
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

   state_t           r_state;
   state_t           w_state_next;

   logic [OP_W-1:0]  r_alu_op;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [WIDTH-1:0] r_out_data;
   logic [1:0]       r_out_flags;
   logic             r_out_valid;
   logic             r_err;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_legal;
   logic             w_unary;
   logic             w_alu_start;
   logic             w_timer_load;
   logic             w_timer_dec;
   logic             w_timer_done;

   assign w_legal    = is_legal(32'(in_data), OP_W);
   assign w_unary    = is_unary(r_alu_op);
   assign w_in_ready = ena && ((r_state == IDLE) || (r_state == LOAD_A) ||
                               (r_state == LOAD_B));
   assign w_accept   = in_valid && w_in_ready;

   // ------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_alu_start  = 1'b0;
      w_timer_load = 1'b0;
      w_timer_dec  = 1'b0;
      if (ena) begin
         case (r_state)
            IDLE: begin
               if (w_accept && w_legal) w_state_next = LOAD_A;
            end
            LOAD_A: begin
               if (w_accept) w_state_next = w_unary ? EXEC : LOAD_B;
            end
            LOAD_B: begin
               if (w_accept) w_state_next = EXEC;
            end
            EXEC: begin
               w_alu_start  = 1'b1;
               w_timer_load = 1'b1;
               w_state_next = WAIT;
            end
            WAIT: begin
               if (w_timer_done) w_state_next = DONE;
               else              w_timer_dec  = 1'b1;
            end
            DONE: begin
               if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else if (ena) begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Opcode/operand/result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_out_data  <= '0;
         r_out_flags <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else if (ena) begin
         r_err <= (r_state == IDLE) && w_accept && !w_legal;
         case (r_state)
            IDLE: begin
               if (w_accept && w_legal) r_alu_op <= in_data[OP_W-1:0];
            end
            LOAD_A: begin
               if (w_accept) begin
                  r_alu_a <= in_data;
                  if (w_unary) r_alu_b <= '0;
               end
            end
            LOAD_B: begin
               if (w_accept) r_alu_b <= in_data;
            end
            WAIT: begin
               if (w_timer_done) begin
                  r_out_data  <= alu_result;
                  r_out_flags <= {alu_carry, (alu_result == '0)};
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   alu_seq_lat_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_ena      (ena),
      .i_load     (w_timer_load),
      .i_load_val (LAT_LOAD),
      .i_dec      (w_timer_dec),
      .o_done     (w_timer_done)
   );

   assign in_ready  = w_in_ready;
   assign alu_start = w_alu_start;
   assign alu_op    = r_alu_op;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_flags = r_out_flags;
   assign err       = r_err;
   assign busy      = (r_state != IDLE);
   assign state_dbg = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Bench for alu_op_sequencer. dut runs at ALU_LAT=1 with a scoreboard/monitor;
// dut4 runs at ALU_LAT=4 for latency, back-pressure and async reset checks.
// Both drive a combinational stub ALU.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int last_acc_cyc = 0;

   // ---------------- stub ALU ----------------
   function automatic logic [8:0] stub_alu(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
      logic [8:0] r;
      case (op)
         3'd0: r = {1'b0, a} + {1'b0, b};
         3'd1: r = {1'b0, a} - {1'b0, b};
         3'd2: r = {1'b0, a & b};
         3'd3: r = {1'b0, a | b};
         3'd4: r = {1'b0, a ^ b};
         3'd5: r = {1'b0, ~a};
         3'd6: r = {a, 1'b0};
         default: r = 9'd0;
      endcase
      return r;
   endfunction

   // ---------------- dut (ALU_LAT=1) ----------------
   logic       rst_n, ena, in_valid, in_ready, alu_start, alu_carry;
   logic       out_valid, out_ready, err, busy;
   logic [7:0] in_data, alu_a, alu_b, alu_result, out_data;
   logic [2:0] alu_op, state_dbg;
   logic [1:0] out_flags;

   assign {alu_carry, alu_result} = stub_alu(alu_op, alu_a, alu_b);

   alu_op_sequencer #(.WIDTH(8), .OP_W(3), .ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_flags(out_flags), .err(err), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- dut4 (ALU_LAT=4) ----------------
   logic       rst4_n, ena4, in4_valid, in4_ready, alu4_start, alu4_carry;
   logic       out4_valid, out4_ready, err4, busy4;
   logic [7:0] in4_data, alu4_a, alu4_b, alu4_result, out4_data;
   logic [2:0] alu4_op, st4;
   logic [1:0] out4_flags;

   assign {alu4_carry, alu4_result} = stub_alu(alu4_op, alu4_a, alu4_b);

   alu_op_sequencer #(.WIDTH(8), .OP_W(3), .ALU_LAT(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .ena(ena4),
      .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data),
      .alu_start(alu4_start), .alu_op(alu4_op), .alu_a(alu4_a), .alu_b(alu4_b),
      .alu_result(alu4_result), .alu_carry(alu4_carry),
      .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data),
      .out_flags(out4_flags), .err(err4), .busy(busy4), .state_dbg(st4)
   );

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // ---------------- scoreboard + monitor for dut ----------------
   logic [18:0] exp_alu[$];   // {op, a, b}
   logic [9:0]  exp_out[$];   // {flags, data}
   logic [18:0] mon_alu;
   logic [9:0]  mon_out;
   logic        ov_prev = 1'b0;

   always @(negedge clk) begin
      if (rst_n && ena) begin
         if (alu_start) begin
            if (exp_alu.size() == 0) fail_now("alu_start_unexpected");
            else begin
               mon_alu = exp_alu.pop_front();
               check("alu_inputs", {13'd0, alu_op, alu_a, alu_b}, {13'd0, mon_alu});
            end
         end
         if (out_valid && !ov_prev)
            check("latency", 32'(cyc - last_acc_cyc), 32'd2);
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) fail_now("out_unexpected");
            else begin
               mon_out = exp_out.pop_front();
               check("out_result", {22'd0, out_flags, out_data}, {22'd0, mon_out});
               $display("txn: data=%02h flags=%02b", out_data, out_flags);
            end
         end
      end
      ov_prev = out_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) fail_now("send_timeout");
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic send4(input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      in4_valid = 1'b1;
      in4_data  = b;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in4_ready) ok = 1'b1;
      end
      if (!ok) fail_now("send4_timeout");
      @(posedge clk);
      #1;
      in4_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_out.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_out", 32'(exp_out.size()), 32'd0);
      check("start_count", 32'(exp_alu.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int k;
      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      rst4_n = 1'b0; ena4 = 1'b1; in4_valid = 1'b0; in4_data = 8'h00; out4_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_state", state_dbg, 0);
      check("rst_regs", {alu_op, alu_a, alu_b, out_data, out_flags, err, alu_start}, 0);
      rst_n = 1'b1; rst4_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_state", {state_dbg, in_ready}, {3'd0, 1'b1});

      // ADD 200+80 -> 0x18 with carry
      out_ready = 1'b1;
      exp_alu.push_back({3'd0, 8'hC8, 8'h50});
      exp_out.push_back({2'b10, 8'h18});
      send(8'h00); send(8'hC8); send(8'h50);
      drain();

      // NOT 0xFF -> 0x00, zero flag; LOAD_B skipped, alu_b cleared from 0x50
      out_ready = 1'b0;
      exp_alu.push_back({3'd5, 8'hFF, 8'h00});
      exp_out.push_back({2'b01, 8'h00});
      send(8'h05); send(8'hFF);
      check("unary_skips_load_b", state_dbg, 3);
      check("unary_b_zero", alu_b, 0);
      k = 0;
      while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
      check("not_valid_seen", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_stable", {out_valid, out_flags, out_data}, {1'b1, 2'b01, 8'h00});
      end
      out_ready = 1'b1;
      drain();

      // Illegal opcodes 0x07 and 0x08
      send(8'h07);
      check("err_07", {err, state_dbg, alu_op}, {1'b1, 3'd0, 3'd5});
      @(posedge clk); #1;
      check("err_07_one_cycle", err, 0);
      send(8'h08);
      check("err_08", {err, state_dbg, alu_op}, {1'b1, 3'd0, 3'd5});
      @(posedge clk); #1;
      check("err_08_one_cycle", err, 0);

      // SUB 0x10-0x10 -> 0, zero flag
      exp_alu.push_back({3'd1, 8'h10, 8'h10});
      exp_out.push_back({2'b01, 8'h00});
      send(8'h01); send(8'h10); send(8'h10);
      drain();

      // ena low in LOAD_B with a byte offered
      exp_alu.push_back({3'd3, 8'h0F, 8'hF0});
      exp_out.push_back({2'b00, 8'hFF});
      send(8'h03); send(8'h0F);
      ena = 1'b0; in_valid = 1'b1; in_data = 8'hF0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("ena_low_frozen", {in_ready, state_dbg, alu_b}, {1'b0, 3'd2, 8'h10});
      end
      ena = 1'b1;
      send(8'hF0);
      drain();

      // ALU_LAT=4: ADD 3+4, next opcode held valid during WAIT/DONE
      send4(8'h00); send4(8'h03); send4(8'h04);
      in4_valid = 1'b1; in4_data = 8'h02;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         #1;
         check("lat4_valid", out4_valid, (i == 5) ? 1 : 0);
         check("lat4_in_ready", in4_ready, 0);
      end
      check("lat4_result", {out4_flags, out4_data}, {2'b00, 8'h07});
      out4_ready = 1'b1;
      @(posedge clk); #1;
      check("lat4_handshake", {out4_valid, st4}, {1'b0, 3'd0});
      out4_ready = 1'b0;
      @(posedge clk); #1;
      check("lat4_next_opcode", {st4, alu4_op}, {3'd1, 3'd2});
      in4_valid = 1'b0;

      // Async reset while in WAIT
      send4(8'h05); send4(8'h06);
      @(posedge clk); #1;
      check("in_wait", st4, 4);
      #2 rst4_n = 1'b0;
      #1;
      check("async_rst_wait", {st4, busy4, out4_valid, alu4_a, in4_ready},
            {3'd0, 1'b0, 1'b0, 8'h00, 1'b1});
      #1 rst4_n = 1'b1;

      // Async reset while in DONE
      @(posedge clk); #1;
      send4(8'h00); send4(8'h01); send4(8'h01);
      k = 0;
      while (!out4_valid && k < 20) begin @(posedge clk); #1; k++; end
      check("done_result", {out4_valid, out4_data}, {1'b1, 8'h02});
      #2 rst4_n = 1'b0;
      #1;
      check("async_rst_done", {out4_valid, out4_data, st4}, {1'b0, 8'h00, 3'd0});
      #1 rst4_n = 1'b1;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
